// File: rtl/matmul_os_array_pkg.sv
// Shared types and helpers for the output-stationary matmul engine:
// FSM state encoding, flush length and output saturation.
package matmul_pkg;

  typedef enum logic [2:0] {
    MM_IDLE  = 3'd0,
    MM_LOAD  = 3'd1,
    MM_FLUSH = 3'd2,
    MM_DRAIN = 3'd3,
    MM_DONE  = 3'd4
  } mm_state_t;

  localparam int MM_N         = 4;
  localparam int MM_FLUSH_LEN = 2 * MM_N - 1;

  function automatic int flush_len(input int n);
    return 2 * n - 1;
  endfunction

  // acc arrives already sign- or zero-extended to 64 bits; the caller keeps
  // the low out_w bits of the result.
  function automatic logic [63:0] saturate(input logic signed [63:0] acc,
                                           input int out_w,
                                           input logic is_signed);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    if (is_signed) begin
      hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (out_w - 1));
    end else begin
      hi = (64'sd1 <<< out_w) - 64'sd1;
      lo = 64'sd0;
    end
    if (acc > hi)      return hi;
    else if (acc < lo) return lo;
    else               return acc;
  endfunction

endpackage

// File: rtl/matmul_os_array_if.sv
// Streaming control/data bundle of matmul_os_array. Defining MATMUL_ACCUM_EN
// adds the accum request that keeps accumulators across tiles.
interface matmul_os_array_if
  import matmul_pkg::*;
#(
  parameter int N     = 4,
  parameter int DW    = 8,
  parameter int OUT_W = 16,
  parameter int KW    = 16
);
  localparam int IW = $clog2(N);

  logic             start;
  logic [KW-1:0]    k_len;
  logic             is_signed;
`ifdef MATMUL_ACCUM_EN
  logic             accum;
`endif
  logic             in_valid;
  logic [N*DW-1:0]  a_col;
  logic [N*DW-1:0]  b_row;
  logic             in_ready;
  logic             c_valid;
  logic [N*OUT_W-1:0] c_row;
  logic [IW-1:0]    c_idx;
  logic             c_ready;
  logic             busy;
  logic             done;

  modport master (
    output start, k_len, is_signed,
`ifdef MATMUL_ACCUM_EN
    output accum,
`endif
    output in_valid, a_col, b_row, c_ready,
    input  in_ready, c_valid, c_row, c_idx, busy, done
  );

  modport slave (
    input  start, k_len, is_signed,
`ifdef MATMUL_ACCUM_EN
    input  accum,
`endif
    input  in_valid, a_col, b_row, c_ready,
    output in_ready, c_valid, c_row, c_idx, busy, done
  );

endinterface

// File: rtl/matmul_os_array_pe.sv
// One processing element: forwards A right and B down through registers and
// accumulates a*b with a signed or unsigned DW x DW product.
module matmul_pe
  import matmul_pkg::*;
#(
  parameter int DW    = 8,
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             is_signed,
  input  logic [DW-1:0]    a_in,
  input  logic [DW-1:0]    b_in,
  output logic [DW-1:0]    a_out,
  output logic [DW-1:0]    b_out,
  output logic [ACC_W-1:0] acc
);

  logic [DW-1:0]           a_q, a_d;
  logic [DW-1:0]           b_q, b_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [ACC_W-1:0]        prod_ext;
  logic [2*DW-1:0]         prod_u;
  logic signed [2*DW-1:0]  prod_s;

  always_comb begin
    a_d    = a_in;
    b_d    = b_in;
    prod_u = {{DW{1'b0}}, a_in} * {{DW{1'b0}}, b_in};
    // The 2*DW-bit product of sign-extended operands is exact, so truncation is safe.
    prod_s = $signed({{DW{a_in[DW-1]}}, a_in}) * $signed({{DW{b_in[DW-1]}}, b_in});
    if (is_signed) prod_ext = ACC_W'(prod_s);
    else           prod_ext = ACC_W'(prod_u);
    acc_d  = clr ? '0 : acc_q + prod_ext;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end

  assign a_out = a_q;
  assign b_out = b_q;
  assign acc   = acc_q;

endmodule

// File: rtl/matmul_os_array.sv
// Output-stationary N x N systolic matmul: skewed A/B feed, PE grid, FSM and
// row-serial saturated drain. MATMUL_ACCUM_EN enables accumulation across tiles.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start; accumulators hold last tile
// LOAD     | in_ready high, counting k_len beat transfers
// FLUSH    | 2N-1 zero cycles so the last beat reaches PE[N-1][N-1]
// DRAIN    | c_valid high, one result row per c_ready handshake
// DONE     | one-cycle done pulse, then IDLE
module matmul_os_array
  import matmul_pkg::*;
#(
  parameter int N     = MM_N,
  parameter int DW    = 8,
  parameter int ACC_W = 32,
  parameter int OUT_W = 16,
  parameter int KW    = 16
) (
  input  logic clk,
  input  logic reset,
  matmul_os_array_if.slave io
);

  localparam int IW        = $clog2(N);
  localparam int FLUSH_LEN = MM_FLUSH_LEN + 2 * (N - MM_N);
  localparam int FW        = $clog2(FLUSH_LEN);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_LEN - 1);

  mm_state_t         state_q, state_d;
  logic [KW-1:0]     beat_q, beat_d;
  logic [FW-1:0]     flush_q, flush_d;
  logic [IW-1:0]     row_q, row_d;
  logic              sgn_q, sgn_d;
  logic              clr;
  logic              xfer;

  logic [DW-1:0]     a_lane [N];
  logic [DW-1:0]     b_lane [N];
  logic [DW-1:0]     a_h [N][N+1];
  logic [DW-1:0]     b_v [N+1][N];
  logic [ACC_W-1:0]  acc [N][N];
  logic signed [63:0] acc_wide [N];
  logic [N*OUT_W-1:0] c_row;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    flush_d = flush_q;
    row_d   = row_q;
    sgn_d   = sgn_q;
    clr     = 1'b0;
    xfer    = 1'b0;
    unique case (state_q)
      MM_IDLE: begin
        if (io.start) begin
          sgn_d = io.is_signed;
          row_d = '0;
`ifdef MATMUL_ACCUM_EN
          clr   = !io.accum;
`else
          clr   = 1'b1;
`endif
          if (io.k_len == '0) begin
            state_d = MM_DRAIN;
          end else begin
            beat_d  = io.k_len;
            state_d = MM_LOAD;
          end
        end
      end
      MM_LOAD: begin
        if (io.in_valid) begin
          xfer   = 1'b1;
          beat_d = beat_q - 1'b1;
          if (beat_q == KW'(1)) begin
            state_d = MM_FLUSH;
            flush_d = FLUSH_LAST;
          end
        end
      end
      MM_FLUSH: begin
        flush_d = flush_q - 1'b1;
        if (flush_q == '0) state_d = MM_DRAIN;
      end
      MM_DRAIN: begin
        if (io.c_ready) begin
          if (row_q == IW'(N - 1)) begin
            row_d   = '0;
            state_d = MM_DONE;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      MM_DONE: state_d = MM_IDLE;
      default: state_d = MM_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MM_IDLE;
      beat_q  <= '0;
      flush_q <= '0;
      row_q   <= '0;
      sgn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      flush_q <= flush_d;
      row_q   <= row_d;
      sgn_q   <= sgn_d;
    end
  end

  // Non-transfer cycles feed zeros, so bubbles and flush add nothing to the sums.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_lane[i] = xfer ? io.a_col[i*DW +: DW] : '0;
      b_lane[i] = xfer ? io.b_row[i*DW +: DW] : '0;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign a_h[0][0] = a_lane[0];
      assign b_v[0][0] = b_lane[0];
    end else begin : g_dly
      logic [DW-1:0] a_sr_q [i];
      logic [DW-1:0] a_sr_d [i];
      logic [DW-1:0] b_sr_q [i];
      logic [DW-1:0] b_sr_d [i];

      always_comb begin
        a_sr_d[0] = a_lane[i];
        b_sr_d[0] = b_lane[i];
        for (int s = 1; s < i; s++) begin
          a_sr_d[s] = a_sr_q[s-1];
          b_sr_d[s] = b_sr_q[s-1];
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          a_sr_q <= '{default: '0};
          b_sr_q <= '{default: '0};
        end else begin
          a_sr_q <= a_sr_d;
          b_sr_q <= b_sr_d;
        end
      end

      assign a_h[i][0] = a_sr_q[i-1];
      assign b_v[0][i] = b_sr_q[i-1];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      matmul_pe #(
        .DW    (DW),
        .ACC_W (ACC_W)
      ) u_pe (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .is_signed (sgn_q),
        .a_in      (a_h[i][j]),
        .b_in      (b_v[i][j]),
        .a_out     (a_h[i][j+1]),
        .b_out     (b_v[i+1][j]),
        .acc       (acc[i][j])
      );
    end
  end

  always_comb begin
    c_row = '0;
    for (int j = 0; j < N; j++) begin
      if (sgn_q) acc_wide[j] = 64'($signed(acc[row_q][j]));
      else       acc_wide[j] = 64'(acc[row_q][j]);
      if (state_q == MM_DRAIN)
        c_row[j*OUT_W +: OUT_W] = OUT_W'(saturate(acc_wide[j], OUT_W, sgn_q));
    end
  end

  assign io.in_ready = (state_q == MM_LOAD);
  assign io.c_valid  = (state_q == MM_DRAIN);
  assign io.c_row    = c_row;
  assign io.c_idx    = row_q;
  assign io.busy     = (state_q != MM_IDLE);
  assign io.done     = (state_q == MM_DONE);

endmodule
